// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer plus tick-qualified FSM with registered level and edge pulses.
// Define DEBOUNCE_TOGGLE_EN to add the toggle_out press-on/press-off latch output.
module button_debouncer #(
  parameter int STABLE_COUNT = 4
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic button_in,
  output logic button_out,
`ifdef DEBOUNCE_TOGGLE_EN
  output logic toggle_out,
`endif
  output logic rise_pulse,
  output logic fall_pulse
);

  // state       | meaning
  // STABLE_LOW  | debounced level is 0, watching for s2=1
  // WAIT_HIGH   | s2=1 seen, counting consecutive high ticks
  // STABLE_HIGH | debounced level is 1, watching for s2=0
  // WAIT_LOW    | s2=0 seen, counting consecutive low ticks

  localparam int CNT_W = $clog2(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s1, s2;
  logic             out_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STABLE_LOW;
      cnt        <= '0;
      button_out <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      button_out <= out_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = button_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (sample_tick) begin
      case (state)
        STABLE_LOW: begin
          if (s2) begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!s2) begin
            state_nxt = STABLE_LOW;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = STABLE_HIGH;
            cnt_nxt   = '0;
            out_nxt   = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s2) begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = CNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (s2) begin
            state_nxt = STABLE_HIGH;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = STABLE_LOW;
            cnt_nxt   = '0;
            out_nxt   = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  // Flips one cycle after each registered rise pulse.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) toggle_out <= 1'b0;
    else if (rise_pulse) toggle_out <= ~toggle_out;
  end
`endif

endmodule
